alu_op_scan_controller: RTL and testbench

Sequencing controller for the shared 4-bit ALU and 7-segment display path. On a `start` request it latches one operand pair. It then steps the ALU through all four op codes (0-3), one per cycle, and buffers the four results. Finally it time-multiplexes the four results onto a 4-digit 7-segment display as hex glyphs. It sits between the operand switches/buttons and the existing ALU datapath. It owns the ALU's operand and op-code inputs and the display drive.

---
 rtl/alu_op_scan_if.sv | 26 ++
 rtl/alu_op_scan_controller.sv | 136 +++++++++++++
 tb/tb_alu_op_scan_controller.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_scan_if.sv
// Bus between the operand switches/ALU/display and the op-scan controller.
// Handshake: start is a level request sampled only while the controller is idle; busy high means it is ignored.
interface alu_op_scan_if #(parameter int WIDTH = 4);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             en;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             busy;
  logic             done;
  logic [6:0]       seg;
  logic [3:0]       an;

  modport master (
    output start, a, b, en, alu_result,
    input  alu_a, alu_b, alu_op, busy, done, seg, an
  );

  modport slave (
    input  start, a, b, en, alu_result,
    output alu_a, alu_b, alu_op, busy, done, seg, an
  );
endinterface

// File: rtl/alu_op_scan_controller.sv
// Steps a shared ALU through op codes 0..3 for one latched operand pair and
// scans the four buffered results onto a 4-digit 7-segment display.
module alu_op_scan_controller #(
  parameter int WIDTH       = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic               clk,
  input  logic               rst,
  alu_op_scan_if.slave       bus,
  output logic [1:0]         state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EVAL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);

  logic [1:0]            state_q, state_d;
  logic [1:0]            op_cnt_q, op_cnt_d;
  logic [WIDTH-1:0]      alu_a_q, alu_a_d;
  logic [WIDTH-1:0]      alu_b_q, alu_b_d;
  logic [2:0][WIDTH-1:0] shadow_q, shadow_d;
  logic [3:0][WIDTH-1:0] bank_q, bank_d;
  logic [RW-1:0]         refresh_cnt_q, refresh_cnt_d;
  logic [1:0]            digit_q, digit_d;
  logic                  refresh_wrap;

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'h7E;
      4'h1: g = 7'h30;
      4'h2: g = 7'h6D;
      4'h3: g = 7'h79;
      4'h4: g = 7'h33;
      4'h5: g = 7'h5B;
      4'h6: g = 7'h5F;
      4'h7: g = 7'h70;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h7B;
      4'hA: g = 7'h77;
      4'hB: g = 7'h1F;
      4'hC: g = 7'h4E;
      4'hD: g = 7'h3D;
      4'hE: g = 7'h4F;
      default: g = 7'h47;
    endcase
    return g;
  endfunction

  always_comb begin
    state_d  = state_q;
    op_cnt_d = op_cnt_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    shadow_d = shadow_q;
    bank_d   = bank_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          alu_a_d  = bus.a;
          alu_b_d  = bus.b;
          op_cnt_d = 2'd0;
          state_d  = S_EVAL;
        end
      end
      S_EVAL: begin
        op_cnt_d = op_cnt_q + 2'd1;
        case (op_cnt_q)
          2'd0: shadow_d[0] = bus.alu_result;
          2'd1: shadow_d[1] = bus.alu_result;
          2'd2: shadow_d[2] = bus.alu_result;
          default: begin
            // Bank loads in one shot so the display never shows a mixed set.
            bank_d  = {bus.alu_result, shadow_q[2], shadow_q[1], shadow_q[0]};
            state_d = S_DONE;
          end
        endcase
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign refresh_wrap = (refresh_cnt_q == REFRESH_LAST);

  always_comb begin
    refresh_cnt_d = refresh_cnt_q + RW'(1);
    digit_d       = digit_q;
    if (refresh_wrap) begin
      refresh_cnt_d = '0;
      digit_d       = digit_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      op_cnt_q      <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      shadow_q      <= '0;
      bank_q        <= '0;
      refresh_cnt_q <= '0;
      digit_q       <= '0;
    end else begin
      state_q       <= state_d;
      op_cnt_q      <= op_cnt_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      shadow_q      <= shadow_d;
      bank_q        <= bank_d;
      refresh_cnt_q <= refresh_cnt_d;
      digit_q       <= digit_d;
    end
  end

  assign bus.alu_a  = alu_a_q;
  assign bus.alu_b  = alu_b_q;
  assign bus.alu_op = (state_q == S_EVAL) ? op_cnt_q : 2'd0;
  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = (state_q == S_DONE);
  assign state_dbg  = state_q;

  always_comb begin
    bus.seg = 7'd0;
    bus.an  = 4'd0;
    if (bus.en) begin
      bus.seg = hex_glyph(bank_q[digit_q]);
      bus.an  = 4'b0001 << digit_q;
    end
  end

endmodule

// File: tb/tb_alu_op_scan_controller.sv
// Randomized bench for alu_op_scan_controller against a behavioural model of
// the 4-op sweep, result bank and digit scan.
module tb_alu_op_scan_controller;
  localparam int DIV = 4;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;
  int         vectors;
  int         miscompares;
  int         scan_n;
  logic [3:0] exp_bank [4];
  logic [3:0] exp_q [$];
  logic [6:0] glyph_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  alu_op_scan_if #(.WIDTH(4)) bus ();

  alu_op_scan_controller #(.WIDTH(4), .REFRESH_DIV(DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  function automatic logic [3:0] alu_ref(input logic [1:0] op, input logic [3:0] x, input logic [3:0] y);
    case (op)
      2'd0:    return x + y;
      2'd1:    return x - y;
      2'd2:    return x & y;
      default: return x | y;
    endcase
  endfunction

  // Combinational ALU sitting on the controller's operand/op outputs.
  assign bus.alu_result = alu_ref(bus.alu_op, bus.alu_a, bus.alu_b);

  // Digit position model: edges elapsed since reset, DIV edges per digit.
  always @(posedge clk or posedge rst) begin
    if (rst) scan_n <= 0;
    else     scan_n <= scan_n + 1;
  end

  function automatic int cur_digit();
    return (scan_n / DIV) % 4;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    int d;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) exp_bank[i] = 4'h0;
    rst = 1'b0;
    vectors++;
    if (bus.alu_a !== 4'h0 || bus.alu_b !== 4'h0 || bus.alu_op !== 2'd0 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: alu_a=%h alu_b=%h op=%0d busy=%b done=%b expected all 0",
               bus.alu_a, bus.alu_b, bus.alu_op, bus.busy, bus.done);
    end
    vectors++;
    if (bus.seg !== 7'h7E || bus.an !== 4'b0001) begin
      miscompares++;
      $display("FAIL reset_disp: seg=%h an=%b expected seg=7e an=0001", bus.seg, bus.an);
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      d = cur_digit();
      vectors++;
      if (bus.seg !== 7'h7E || bus.an !== (4'b0001 << d)) begin
        miscompares++;
        $display("FAIL reset_scan: seg=%h an=%b expected seg=7e an=%b", bus.seg, bus.an, 4'b0001 << d);
      end
    end
  endtask

  task automatic test_basic();
    int d;
    bus.a = 4'h9; bus.b = 4'h5; bus.start = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(alu_ref(2'(i), 4'h9, 4'h5));
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      vectors++;
      if (bus.alu_op !== 2'(i) || bus.busy !== 1'b1 || bus.done !== 1'b0 ||
          bus.alu_a !== 4'h9 || bus.alu_b !== 4'h5) begin
        miscompares++;
        $display("FAIL basic_eval: op=%0d busy=%b done=%b a=%h b=%h expected op=%0d busy=1 done=0 a=9 b=5",
                 bus.alu_op, bus.busy, bus.done, bus.alu_a, bus.alu_b, i);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) exp_bank[i] = exp_q.pop_front();
    d = cur_digit();
    vectors++;
    if (bus.done !== 1'b1 || bus.alu_op !== 2'd0 || bus.seg !== glyph_tab[exp_bank[d]]) begin
      miscompares++;
      $display("FAIL basic_done: done=%b op=%0d seg=%h expected done=1 op=0 seg=%h",
               bus.done, bus.alu_op, bus.seg, glyph_tab[exp_bank[d]]);
    end
    @(negedge clk);
    vectors++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_idle: done=%b busy=%b expected 0 0", bus.done, bus.busy);
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      d = cur_digit();
      vectors++;
      if (bus.seg !== glyph_tab[exp_bank[d]] || bus.an !== (4'b0001 << d)) begin
        miscompares++;
        $display("FAIL basic_scan: seg=%h an=%b expected seg=%h an=%b",
                 bus.seg, bus.an, glyph_tab[exp_bank[d]], 4'b0001 << d);
      end
    end
  endtask

  task automatic test_back_to_back();
    int d;
    logic exp_done, exp_busy;
    bus.a = 4'hF; bus.b = 4'h1; bus.start = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      exp_done = (c % 6 == 5);
      exp_busy = (c % 6 != 0);
      if (exp_done)
        for (int i = 0; i < 4; i++) exp_bank[i] = alu_ref(2'(i), 4'hF, 4'h1);
      vectors++;
      if (bus.done !== exp_done || bus.busy !== exp_busy) begin
        miscompares++;
        $display("FAIL b2b_cycle%0d: done=%b busy=%b expected done=%b busy=%b",
                 c, bus.done, bus.busy, exp_done, exp_busy);
      end
    end
    bus.start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      d = cur_digit();
      vectors++;
      if (bus.seg !== glyph_tab[exp_bank[d]] || (d == 0 && bus.seg !== 7'h7E)) begin
        miscompares++;
        $display("FAIL b2b_scan: seg=%h expected %h", bus.seg, glyph_tab[exp_bank[d]]);
      end
    end
  endtask

  task automatic test_operand_change();
    int d;
    bus.a = 4'h3; bus.b = 4'h6; bus.start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (c == 2) begin
        bus.a = 4'(4'hC ^ $urandom_range(0, 3));
        bus.b = 4'(4'hA ^ $urandom_range(0, 3));
      end
      if (c == 3) bus.start = 1'b1;
      if (c == 5)
        for (int i = 0; i < 4; i++) exp_bank[i] = alu_ref(2'(i), 4'h3, 4'h6);
      vectors++;
      if (bus.alu_a !== 4'h3 || bus.alu_b !== 4'h6 || bus.busy !== (c <= 5) ||
          bus.done !== (c == 5) || (c <= 4 && bus.alu_op !== 2'(c - 1))) begin
        miscompares++;
        $display("FAIL opchg_cycle%0d: a=%h b=%h busy=%b done=%b op=%0d", c,
                 bus.alu_a, bus.alu_b, bus.busy, bus.done, bus.alu_op);
      end
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      d = cur_digit();
      vectors++;
      if (bus.seg !== glyph_tab[exp_bank[d]]) begin
        miscompares++;
        $display("FAIL opchg_scan: seg=%h expected %h", bus.seg, glyph_tab[exp_bank[d]]);
      end
    end
  endtask

  task automatic test_reset_midrun();
    int d;
    bus.a = 4'h7; bus.b = 4'h2; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.alu_op !== 2'd2 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_pre: op=%0d busy=%b expected op=2 busy=1", bus.alu_op, bus.busy);
    end
    rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) exp_bank[i] = 4'h0;
    vectors++;
    if (bus.alu_a !== 4'h0 || bus.alu_b !== 4'h0 || bus.alu_op !== 2'd0 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0 || bus.seg !== 7'h7E || bus.an !== 4'b0001) begin
      miscompares++;
      $display("FAIL rstmid_now: a=%h b=%h op=%0d busy=%b done=%b seg=%h an=%b expected reset values",
               bus.alu_a, bus.alu_b, bus.alu_op, bus.busy, bus.done, bus.seg, bus.an);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      d = cur_digit();
      vectors++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.seg !== 7'h7E || bus.an !== (4'b0001 << d)) begin
        miscompares++;
        $display("FAIL rstmid_after: done=%b busy=%b seg=%h an=%b expected 0 0 7e %b",
                 bus.done, bus.busy, bus.seg, bus.an, 4'b0001 << d);
      end
    end
  endtask

  task automatic test_enable();
    int d;
    logic [3:0] ra, rb;
    ra = 4'($urandom_range(0, 15));
    rb = 4'($urandom_range(0, 15));
    bus.en = 1'b0;
    bus.a = ra; bus.b = rb; bus.start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      vectors++;
      if (bus.seg !== 7'h00 || bus.an !== 4'h0 || bus.done !== (c == 5)) begin
        miscompares++;
        $display("FAIL en_blank%0d: seg=%h an=%b done=%b expected seg=00 an=0000", c, bus.seg, bus.an, bus.done);
      end
    end
    for (int i = 0; i < 4; i++) exp_bank[i] = alu_ref(2'(i), ra, rb);
    bus.en = 1'b1;
    #1;
    d = cur_digit();
    vectors++;
    if (bus.seg !== glyph_tab[exp_bank[d]] || bus.an !== (4'b0001 << d)) begin
      miscompares++;
      $display("FAIL en_return: seg=%h an=%b expected seg=%h an=%b",
               bus.seg, bus.an, glyph_tab[exp_bank[d]], 4'b0001 << d);
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      d = cur_digit();
      vectors++;
      if (bus.seg !== glyph_tab[exp_bank[d]] || bus.an !== (4'b0001 << d)) begin
        miscompares++;
        $display("FAIL en_scan: seg=%h an=%b expected seg=%h an=%b",
                 bus.seg, bus.an, glyph_tab[exp_bank[d]], 4'b0001 << d);
      end
    end
  endtask

  task automatic test_random();
    int d;
    logic [3:0] ra, rb;
    for (int r = 0; r < 8; r++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      for (int i = 0; i < 4; i++) exp_q.push_back(alu_ref(2'(i), ra, rb));
      bus.a = ra; bus.b = rb; bus.start = 1'b1;
      for (int c = 1; c <= 6; c++) begin
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = 4'($urandom_range(0, 15));
        bus.b = 4'($urandom_range(0, 15));
        if (c == 5)
          for (int i = 0; i < 4; i++) exp_bank[i] = exp_q.pop_front();
        d = cur_digit();
        vectors++;
        if (bus.alu_a !== ra || bus.alu_b !== rb || bus.done !== (c == 5) ||
            bus.busy !== (c <= 5) || (c <= 4 && bus.alu_op !== 2'(c - 1)) ||
            (c >= 5 && bus.seg !== glyph_tab[exp_bank[d]])) begin
          miscompares++;
          $display("FAIL rand%0d_cycle%0d: a=%h b=%h op=%0d busy=%b done=%b seg=%h (a=%h b=%h)",
                   r, c, bus.alu_a, bus.alu_b, bus.alu_op, bus.busy, bus.done, bus.seg, ra, rb);
        end
      end
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        d = cur_digit();
        vectors++;
        if (bus.seg !== glyph_tab[exp_bank[d]] || bus.an !== (4'b0001 << d)) begin
          miscompares++;
          $display("FAIL rand%0d_scan: seg=%h an=%b expected seg=%h an=%b",
                   r, bus.seg, bus.an, glyph_tab[exp_bank[d]], 4'b0001 << d);
        end
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.a       = 4'h0;
    bus.b       = 4'h0;
    bus.en      = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_operand_change();
    test_reset_midrun();
    test_enable();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
